mux2_rr_arbiter: RTL and testbench

MUX2_RR_ARBITER -- requirements
Module: mux2_rr_arbiter

---
 rtl/mux2_rr_arbiter_pkg.sv | 8 +
 rtl/mux2_rr_arbiter_grant.sv | 37 +++
 rtl/mux2_rr_arbiter.sv | 63 ++++++
 tb/tb_mux2_rr_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared constants for the two-channel round-robin arbiter and its grant logic.
package mux2_rr_arbiter_pkg;

   localparam int   DEFAULT_WIDTH = 8;
   localparam logic CH0           = 1'b0;
   localparam logic CH1           = 1'b1;

endpackage

// File: rtl/mux2_rr_arbiter_grant.sv
// Combinational two-way grant: lock override first, then round-robin against the last-grant pointer.
module rr_grant2
   import mux2_rr_arbiter_pkg::*;
(
   input  logic valid0,
   input  logic valid1,
   input  logic ptr,
   input  logic lock,
   input  logic lock_ch,
   input  logic space,
   output logic grant0,
   output logic grant1
);

   // A locked channel keeps the grant only while it is still requesting.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (space) begin
         if (lock && (lock_ch == CH0) && valid0) begin
            grant0 = 1'b1;
         end else if (lock && (lock_ch == CH1) && valid1) begin
            grant1 = 1'b1;
         end else if (valid0 && valid1) begin
            if (ptr == CH0) begin
               grant1 = 1'b1;
            end else begin
               grant0 = 1'b1;
            end
         end else begin
            grant0 = valid0;
            grant1 = valid1;
         end
      end
   end

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Two-input round-robin arbiter feeding a single registered output stage with valid/ready handshakes.
module mux2_rr_arbiter
   import mux2_rr_arbiter_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in0_valid,
   input  logic [WIDTH-1:0] in0_data,
   output logic             in0_ready,
   input  logic             in1_valid,
   input  logic [WIDTH-1:0] in1_data,
   output logic             in1_ready,
   input  logic             lock,
   output logic             sel,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready
);

   logic space;
   logic grant0;
   logic grant1;
   logic last_grant;
   logic in_xfer;

   // Reset suppresses space so nothing can be accepted in a reset cycle.
   assign space   = !rst && (!out_valid || out_ready);
   assign in_xfer = grant0 || grant1;

   rr_grant2 u_grant (
      .valid0  (in0_valid),
      .valid1  (in1_valid),
      .ptr     (last_grant),
      .lock    (lock && out_valid),
      .lock_ch (sel),
      .space   (space),
      .grant0  (grant0),
      .grant1  (grant1)
   );

   assign in0_ready = grant0;
   assign in1_ready = grant1;

   // Output register, source index and last-grant pointer; pointer resets to CH1 so CH0 wins first.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         sel        <= CH0;
         last_grant <= CH1;
      end else if (in_xfer) begin
         out_valid  <= 1'b1;
         out_data   <= grant1 ? in1_data : in0_data;
         sel        <= grant1 ? CH1 : CH0;
         last_grant <= grant1 ? CH1 : CH0;
      end else if (out_valid && out_ready) begin
         out_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed cycle table plus a long randomised scoreboard run for mux2_rr_arbiter.
module tb_mux2_rr_arbiter;

   typedef struct {
      logic       rst;
      logic       v0;
      logic [7:0] d0;
      logic       v1;
      logic [7:0] d1;
      logic       lk;
      logic       ordy;
      logic       er0;
      logic       er1;
      logic       eov;
      logic [7:0] edata;
      logic       esel;
   } vec_t;

   typedef struct packed {
      logic       src;
      logic [7:0] data;
   } word_t;

   logic       clk;
   logic       rst;
   logic       in0_valid;
   logic [7:0] in0_data;
   logic       in0_ready;
   logic       in1_valid;
   logic [7:0] in1_data;
   logic       in1_ready;
   logic       lock;
   logic       sel;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_ready;

   int checks = 0;
   int errors = 0;

   vec_t  vecs[24];
   word_t sbq[$];

   mux2_rr_arbiter #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in0_valid (in0_valid),
      .in0_data  (in0_data),
      .in0_ready (in0_ready),
      .in1_valid (in1_valid),
      .in1_data  (in1_data),
      .in1_ready (in1_ready),
      .lock      (lock),
      .sel       (sel),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic r, input logic v0, input logic [7:0] d0,
                               input logic v1, input logic [7:0] d1, input logic lk,
                               input logic ordy, input logic er0, input logic er1,
                               input logic eov, input logic [7:0] edata, input logic esel);
      vec_t v;
      v.rst = r;    v.v0 = v0;    v.d0 = d0;   v.v1 = v1;     v.d1 = d1;
      v.lk = lk;    v.ordy = ordy;
      v.er0 = er0;  v.er1 = er1;  v.eov = eov; v.edata = edata; v.esel = esel;
      return v;
   endfunction

   task automatic applyStimulus(input logic r, input logic v0, input logic [7:0] d0,
                                input logic v1, input logic [7:0] d1, input logic lk,
                                input logic ordy);
      rst       = r;
      in0_valid = v0;
      in0_data  = d0;
      in1_valid = v1;
      in1_data  = d1;
      lock      = lk;
      out_ready = ordy;
   endtask

   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   initial begin
      word_t      w;
      logic       mov;
      logic [7:0] mdata;
      logic       msel;
      logic       mptr;
      logic       mspace;
      logic       eg0;
      logic       eg1;

      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

      // Cycle trace: reset, alternation, back-pressure, lock burst, single channel, drain, lock corners, reset mid-hold.
      vecs[0]  = mk(1, 0, 8'h00, 0, 8'h00, 0, 0,  0, 0, 0, 8'h00, 0);
      vecs[1]  = mk(1, 1, 8'hA5, 1, 8'h5A, 0, 1,  0, 0, 0, 8'h00, 0);
      vecs[2]  = mk(0, 1, 8'hA5, 1, 8'h5A, 0, 1,  1, 0, 1, 8'hA5, 0);
      vecs[3]  = mk(0, 1, 8'hA5, 1, 8'h5A, 0, 1,  0, 1, 1, 8'h5A, 1);
      vecs[4]  = mk(0, 1, 8'hA5, 1, 8'h5A, 0, 1,  1, 0, 1, 8'hA5, 0);
      vecs[5]  = mk(0, 1, 8'hA5, 1, 8'h5A, 0, 1,  0, 1, 1, 8'h5A, 1);
      vecs[6]  = mk(0, 1, 8'hA5, 1, 8'h5A, 0, 0,  0, 0, 1, 8'h5A, 1);
      vecs[7]  = mk(0, 1, 8'hA5, 1, 8'h5A, 0, 0,  0, 0, 1, 8'h5A, 1);
      vecs[8]  = mk(0, 1, 8'hA5, 1, 8'h5A, 0, 0,  0, 0, 1, 8'h5A, 1);
      vecs[9]  = mk(0, 1, 8'hA5, 1, 8'h5A, 0, 1,  1, 0, 1, 8'hA5, 0);
      vecs[10] = mk(0, 1, 8'h01, 1, 8'h5A, 1, 1,  1, 0, 1, 8'h01, 0);
      vecs[11] = mk(0, 1, 8'h02, 1, 8'h5A, 1, 1,  1, 0, 1, 8'h02, 0);
      vecs[12] = mk(0, 1, 8'h03, 1, 8'h5A, 1, 1,  1, 0, 1, 8'h03, 0);
      vecs[13] = mk(0, 1, 8'h04, 1, 8'h5A, 1, 1,  1, 0, 1, 8'h04, 0);
      vecs[14] = mk(0, 1, 8'h05, 1, 8'h5A, 0, 1,  0, 1, 1, 8'h5A, 1);
      vecs[15] = mk(0, 0, 8'h00, 1, 8'h33, 0, 1,  0, 1, 1, 8'h33, 1);
      vecs[16] = mk(0, 0, 8'h00, 1, 8'h33, 0, 1,  0, 1, 1, 8'h33, 1);
      vecs[17] = mk(0, 0, 8'h00, 0, 8'h00, 0, 1,  0, 0, 0, 8'h33, 1);
      vecs[18] = mk(0, 0, 8'h00, 0, 8'h00, 0, 0,  0, 0, 0, 8'h33, 1);
      vecs[19] = mk(0, 1, 8'hA5, 1, 8'h5A, 1, 0,  1, 0, 1, 8'hA5, 0);
      vecs[20] = mk(0, 0, 8'h00, 1, 8'h5A, 1, 1,  0, 1, 1, 8'h5A, 1);
      vecs[21] = mk(1, 1, 8'hA5, 1, 8'h5A, 0, 0,  0, 0, 0, 8'h00, 0);
      vecs[22] = mk(0, 1, 8'hA5, 1, 8'h5A, 0, 1,  1, 0, 1, 8'hA5, 0);
      vecs[23] = mk(0, 0, 8'h00, 0, 8'h00, 0, 1,  0, 0, 0, 8'hA5, 0);

      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         applyStimulus(vecs[i].rst, vecs[i].v0, vecs[i].d0, vecs[i].v1, vecs[i].d1,
                       vecs[i].lk, vecs[i].ordy);
         #1;
         checkOutput($sformatf("v%0d.in0_ready", i), 8'(in0_ready), 8'(vecs[i].er0));
         checkOutput($sformatf("v%0d.in1_ready", i), 8'(in1_ready), 8'(vecs[i].er1));
         @(posedge clk);
         #1;
         checkOutput($sformatf("v%0d.out_valid", i), 8'(out_valid), 8'(vecs[i].eov));
         checkOutput($sformatf("v%0d.out_data", i), out_data, vecs[i].edata);
         checkOutput($sformatf("v%0d.sel", i), 8'(sel), 8'(vecs[i].esel));
      end

      // Randomised run: a reference model predicts readies/outputs, a queue checks order and uniqueness.
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      mov  = 1'b0;
      mdata = 8'h00;
      msel = 1'b0;
      mptr = 1'b1;
      sbq.delete();

      for (int c = 0; c < 10000; c++) begin
         @(negedge clk);
         applyStimulus(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                       8'($urandom), (c >= 5000) ? 1'($urandom_range(0, 1)) : 1'b0,
                       ($urandom_range(0, 3) != 0));
         #1;
         if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL rnd%0d.dup: got word %0h, expected none pending", c, out_data);
            end else begin
               w = sbq.pop_front();
               checkOutput($sformatf("rnd%0d.order_data", c), out_data, w.data);
               checkOutput($sformatf("rnd%0d.order_sel", c), 8'(sel), 8'(w.src));
            end
         end

         mspace = !mov || out_ready;
         eg0 = 1'b0;
         eg1 = 1'b0;
         if (mspace) begin
            if (lock && mov && (msel ? in1_valid : in0_valid)) begin
               eg0 = !msel;
               eg1 = msel;
            end else if (in0_valid && in1_valid) begin
               eg0 = mptr;
               eg1 = !mptr;
            end else begin
               eg0 = in0_valid;
               eg1 = in1_valid;
            end
         end
         checkOutput($sformatf("rnd%0d.in0_ready", c), 8'(in0_ready), 8'(eg0));
         checkOutput($sformatf("rnd%0d.in1_ready", c), 8'(in1_ready), 8'(eg1));

         if (in0_ready) sbq.push_back({1'b0, in0_data});
         if (in1_ready) sbq.push_back({1'b1, in1_data});

         @(posedge clk);
         if (eg0 || eg1) begin
            mov   = 1'b1;
            mdata = eg1 ? in1_data : in0_data;
            msel  = eg1;
            mptr  = eg1;
         end else if (mov && out_ready) begin
            mov = 1'b0;
         end
         #1;
         checkOutput($sformatf("rnd%0d.out_valid", c), 8'(out_valid), 8'(mov));
         if (mov) begin
            checkOutput($sformatf("rnd%0d.out_data", c), out_data, mdata);
            checkOutput($sformatf("rnd%0d.sel", c), 8'(sel), 8'(msel));
         end
      end

      checkOutput("pending_words", 8'(sbq.size()), 8'(mov));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
